// File: rtl/term_loopback_switch_matrix_cfg.sv
// Terminal-tile loopback switch matrix for the array edge.
// Each of NCH incoming W-bit channels is returned to the array in one of four modes:
// reversed passthrough, straight passthrough, registered reversed passthrough, or tie-off.
// Per-channel modes live in a double-buffered serial configuration register.
// The shadow half shifts in from cfg_in and can be chained to the next tile through cfg_out.
// The active half is loaded from the shadow half on cfg_latch.
module term_loopback_switch_matrix_cfg #(
    parameter int NCH        = 4,
    parameter int W          = 8,
    parameter int PIPE_DEPTH = 2
) (
    input  logic               UserCLK,
    input  logic               RST,
    input  logic [NCH*W-1:0]   S_END_I,
    output logic [NCH*W-1:0]   N_BEG_O,
    input  logic               cfg_in,
    input  logic               cfg_shift,
    input  logic               cfg_latch,
    output logic               cfg_out
);

    localparam logic [1:0] MODE_REV  = 2'b00;
    localparam logic [1:0] MODE_PASS = 2'b01;
    localparam logic [1:0] MODE_PIPE = 2'b10;

    logic [2*NCH-1:0]                  shadow;
    logic [2*NCH-1:0]                  active;
    logic [NCH*W-1:0]                  rev;
    logic [PIPE_DEPTH-1:0][NCH*W-1:0]  pipe;

    // Bit-reverse every channel independently; the channel packing is unchanged.
    always_comb begin
        rev = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < W; i++) begin
                rev[c*W + i] = S_END_I[c*W + W - 1 - i];
            end
        end
    end

    // Shadow chain shifts MSB-ward; active captures the pre-shift shadow when both strobes coincide.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (cfg_shift) begin
                shadow <= {shadow[2*NCH-2:0], cfg_in};
            end
            if (cfg_latch) begin
                active <= shadow;
            end
        end
    end

    // Reversed data always flows through the pipeline, so entering registered mode needs no flush.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            pipe <= '0;
        end else begin
            pipe[0] <= rev;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign cfg_out = shadow[2*NCH-1];

    // Per-channel output select; every mode drives all bits so nothing floats or goes X.
    always_comb begin
        N_BEG_O = '0;
        for (int c = 0; c < NCH; c++) begin
            case (active[2*c +: 2])
                MODE_REV:  N_BEG_O[c*W +: W] = rev[c*W +: W];
                MODE_PASS: N_BEG_O[c*W +: W] = S_END_I[c*W +: W];
                MODE_PIPE: N_BEG_O[c*W +: W] = pipe[PIPE_DEPTH-1][c*W +: W];
                default:   N_BEG_O[c*W +: W] = '0;
            endcase
        end
    end

endmodule
